// File: rtl/bike_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bike_pkg                                                             |
// | Shared types and constants for the bike computer datapath blocks:    |
// | divider FSM state encoding, default divider width, client indices.   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package bike_pkg;

   localparam int DIV_WIDTH = 12;

   // Client indices on the shared divider
   localparam logic CLIENT_SPEED = 1'b0;
   localparam logic CLIENT_AVG   = 1'b1;

   // Divider server state; ST_ROUND is only reachable in the rounding build
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_ROUND = 2'd2,
      ST_DONE  = 2'd3
   } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_core                                                             |
// | Restoring divider datapath, one quotient bit per step, MSB first.    |
// | Owns the partial remainder, quotient shift register and step count.  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module div_core #(
   parameter int WIDTH = 12
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             step,
   output logic             last_step,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH:0]   remainder
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   trial;
   logic             fits;

   // The quotient register starts out holding the dividend: its MSB is the
   // next dividend bit to shift into the remainder, and quotient bits fill
   // in from the LSB as dividend bits leave.
   always_comb begin
      rem_d = rem_q;
      quo_d = quo_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
      trial = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      fits  = (trial >= {1'b0, dvs_q});
      if (load) begin
         rem_d = '0;
         quo_d = dividend;
         dvs_d = divisor;
         cnt_d = '0;
      end else if (step) begin
         rem_d = fits ? (trial - {1'b0, dvs_q}) : trial;
         quo_d = {quo_q[WIDTH-2:0], fits};
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
      end
   end

   assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule
`default_nettype wire

// File: rtl/div_server.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_server                                                           |
// | Shared iterative divider serving two clients (speed, average speed)  |
// | with round-robin arbitration and per-client done pulses.             |
// | Optional feature macro: DIV_SERVER_ROUND_EN (round-to-nearest via an |
// | extra ROUND cycle; truncating quotient when undefined).              |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module div_server
   import bike_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0,
   input  logic [WIDTH-1:0] dividend0,
   input  logic [WIDTH-1:0] divisor0,
   input  logic             req1,
   input  logic [WIDTH-1:0] dividend1,
   input  logic [WIDTH-1:0] divisor1,
   output logic [WIDTH-1:0] res,
   output logic             dbz,
   output logic             done0,
   output logic             done1,
   output logic             busy
);

   div_state_t       state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_grant_q, last_grant_d;
   logic             dbz_pend_q, dbz_pend_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             dbz_q, dbz_d;
   logic             done0_q, done0_d;
   logic             done1_q, done1_d;
   logic             busy_q, busy_d;
`ifdef DIV_SERVER_ROUND_EN
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic             round_q, round_d;
`endif

   logic             req0_m, req1_m;
   logic             grant_idx;
   logic [WIDTH-1:0] sel_dividend, sel_divisor;
   logic             load, step, last_step;
   logic [WIDTH-1:0] quotient, result;
   logic [WIDTH:0]   core_rem;

   // A client is still holding its request during the cycle its done pulse
   // is visible; mask it so the finished division is not started again.
   assign req0_m       = req0 & ~done0_q;
   assign req1_m       = req1 & ~done1_q;
   assign grant_idx    = (req0_m & req1_m) ? ~last_grant_q : req1_m;
   assign sel_dividend = grant_idx ? dividend1 : dividend0;
   assign sel_divisor  = grant_idx ? divisor1  : divisor0;

`ifdef DIV_SERVER_ROUND_EN
   assign result = quotient + WIDTH'(round_q);
`else
   assign result = quotient;
   logic unused_rem;
   assign unused_rem = ^core_rem;
`endif

   div_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clock     (clock),
      .reset     (reset),
      .load      (load),
      .dividend  (sel_dividend),
      .divisor   (sel_divisor),
      .step      (step),
      .last_step (last_step),
      .quotient  (quotient),
      .remainder (core_rem)
   );

   // Arbitration, state sequencing and next values of the output registers
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      dbz_pend_d   = dbz_pend_q;
      res_d        = res_q;
      dbz_d        = dbz_q;
      done0_d      = 1'b0;
      done1_d      = 1'b0;
      load         = 1'b0;
      step         = 1'b0;
`ifdef DIV_SERVER_ROUND_EN
      divisor_d    = divisor_q;
      round_d      = round_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req0_m | req1_m) begin
               load         = 1'b1;
               owner_d      = grant_idx;
               last_grant_d = grant_idx;
`ifdef DIV_SERVER_ROUND_EN
               divisor_d    = sel_divisor;
`endif
               if (sel_divisor == '0) begin
                  dbz_pend_d = 1'b1;
                  state_d    = ST_DONE;
               end else begin
                  dbz_pend_d = 1'b0;
                  state_d    = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            step = 1'b1;
            if (last_step) begin
`ifdef DIV_SERVER_ROUND_EN
               state_d = ST_ROUND;
`else
               state_d = ST_DONE;
`endif
            end
         end
`ifdef DIV_SERVER_ROUND_EN
         ST_ROUND: begin
            // Round half up: 2*remainder >= divisor
            round_d = ({core_rem, 1'b0} >= {2'b00, divisor_q});
            state_d = ST_DONE;
         end
`endif
         ST_DONE: begin
            done0_d = (owner_q == CLIENT_SPEED);
            done1_d = (owner_q == CLIENT_AVG);
            dbz_d   = dbz_pend_q;
            res_d   = dbz_pend_q ? '1 : result;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs; reset abandons any division in flight
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= CLIENT_SPEED;
         last_grant_q <= CLIENT_AVG;
         dbz_pend_q   <= 1'b0;
         res_q        <= '0;
         dbz_q        <= 1'b0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         busy_q       <= 1'b0;
`ifdef DIV_SERVER_ROUND_EN
         divisor_q    <= '0;
         round_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         dbz_pend_q   <= dbz_pend_d;
         res_q        <= res_d;
         dbz_q        <= dbz_d;
         done0_q      <= done0_d;
         done1_q      <= done1_d;
         busy_q       <= busy_d;
`ifdef DIV_SERVER_ROUND_EN
         divisor_q    <= divisor_d;
         round_q      <= round_d;
`endif
      end
   end

   assign res   = res_q;
   assign dbz   = dbz_q;
   assign done0 = done0_q;
   assign done1 = done1_q;
   assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_div_server.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div_server                                                        |
// | Directed, table-driven bench for div_server: single divisions,       |
// | tie-break after reset, fairness, divide-by-zero and reset mid-CALC.  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_div_server;

   localparam int W = 12;
`ifdef DIV_SERVER_ROUND_EN
   localparam int LAT = W + 2;
`else
   localparam int LAT = W + 1;
`endif

   logic         clk;
   logic         reset;
   logic         req0, req1;
   logic [W-1:0] dividend0, divisor0, dividend1, divisor1;
   logic [W-1:0] res;
   logic         dbz, done0, done1, busy;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      int client;
      int a;
      int b;
      int exp_res;
      int exp_dbz;
   } vec_t;

   vec_t vecs[10];

   div_server #(.WIDTH(W)) dut (
      .clock     (clk),
      .reset     (reset),
      .req0      (req0),
      .dividend0 (dividend0),
      .divisor0  (divisor0),
      .req1      (req1),
      .dividend1 (dividend1),
      .divisor1  (divisor1),
      .res       (res),
      .dbz       (dbz),
      .done0     (done0),
      .done1     (done1),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Issue one request (called just after a negedge) and wait for its done.
   // lat = edges after the grant edge E0 before done is seen.
   task automatic run_one(input int cl, input int a, input int b,
                          output int r, output int z, output int lat,
                          output int other, output int busy_e0);
      if (cl == 0) begin
         dividend0 = W'(a); divisor0 = W'(b); req0 = 1'b1;
      end else begin
         dividend1 = W'(a); divisor1 = W'(b); req1 = 1'b1;
      end
      @(posedge clk);
      lat = -1; other = 0; r = -1; z = -1; busy_e0 = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 0) busy_e0 = int'(busy);
         if ((cl == 0) ? done1 : done0) other = 1;
         if ((cl == 0) ? done0 : done1) begin
            lat = k; r = int'(res); z = int'(dbz);
            break;
         end
         @(posedge clk);
      end
      if (cl == 0) req0 = 1'b0; else req1 = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int r, z, lat, other, be0, exp_lat;
      int ord[4];
      int rv[4];
      int nd, gap, consec1, issued0, issued1, spurious;
      logic rearm0, rearm1;

      vecs[0] = '{0, 1000, 7, 142, 0};
      vecs[1] = '{1, 55,   0, 4095, 1};
      vecs[2] = '{1, 100,  3, 33, 0};
      vecs[3] = '{0, 0,    9, 0, 0};
      vecs[4] = '{0, 4095, 1, 4095, 0};
      vecs[5] = '{1, 7,    8, 0, 0};
      vecs[6] = '{1, 3000, 10, 300, 0};
      vecs[7] = '{0, 4095, 4095, 1, 0};
      vecs[8] = '{0, 11,   4, 2, 0};
      vecs[9] = '{0, 13,   0, 4095, 1};
`ifdef DIV_SERVER_ROUND_EN
      vecs[0].exp_res = 143;
      vecs[5].exp_res = 1;
      vecs[8].exp_res = 3;
`endif

      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      dividend0 = '0; divisor0 = '0; dividend1 = '0; divisor1 = '0;
      repeat (2) @(negedge clk);
      chk("reset res",   int'(res),   0);
      chk("reset dbz",   int'(dbz),   0);
      chk("reset done0", int'(done0), 0);
      chk("reset done1", int'(done1), 0);
      chk("reset busy",  int'(busy),  0);
      reset = 1'b0;
      @(negedge clk);

      // Single-client divisions from the vector table
      for (int i = 0; i < 10; i++) begin
         exp_lat = (vecs[i].b == 0) ? 1 : LAT;
         run_one(vecs[i].client, vecs[i].a, vecs[i].b, r, z, lat, other, be0);
         chk($sformatf("v%0d res", i), r, vecs[i].exp_res);
         chk($sformatf("v%0d dbz", i), z, vecs[i].exp_dbz);
         chk($sformatf("v%0d latency", i), lat, exp_lat);
         chk($sformatf("v%0d other done", i), other, 0);
         chk($sformatf("v%0d busy at grant", i), be0, 1);
         @(negedge clk);
         chk($sformatf("v%0d done is one cycle", i),
             int'(done0 | done1), 0);
         chk($sformatf("v%0d res held", i), int'(res), vecs[i].exp_res);
      end

      // Simultaneous requests after reset: client 0 wins the first tie
      pulse_reset();
      for (int i = 0; i < 4; i++) begin ord[i] = -1; rv[i] = -1; end
      nd = 0; gap = 0;
      dividend0 = W'(3000); divisor0 = W'(10);
      dividend1 = W'(4095); divisor1 = W'(4095);
      req0 = 1'b1; req1 = 1'b1;
      for (int c = 0; c < 120 && nd < 2; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done0 && nd < 4) begin ord[nd] = 0; rv[nd] = int'(res); nd++; req0 = 1'b0; end
         if (done1 && nd < 4) begin ord[nd] = 1; rv[nd] = int'(res); nd++; req1 = 1'b0; end
         if (nd == 1 && !busy) gap++;
      end
      chk("tie completions", nd, 2);
      chk("tie first client", ord[0], 0);
      chk("tie first res", rv[0], 300);
      chk("tie second client", ord[1], 1);
      chk("tie second res", rv[1], 1);
      chk("tie busy gap cycles", gap, 1);

      // Fairness: both clients keep requesting for four transactions
      pulse_reset();
      for (int i = 0; i < 4; i++) begin ord[i] = -1; rv[i] = -1; end
      nd = 0; consec1 = 0; issued0 = 1; issued1 = 1;
      rearm0 = 1'b0; rearm1 = 1'b0;
      dividend0 = W'(200); divisor0 = W'(5);
      dividend1 = W'(90);  divisor1 = W'(9);
      req0 = 1'b1; req1 = 1'b1;
      for (int c = 0; c < 200 && nd < 4; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (rearm0) begin req0 = 1'b1; rearm0 = 1'b0; end
         if (rearm1) begin req1 = 1'b1; rearm1 = 1'b0; end
         if (done0 && nd < 4) begin
            ord[nd] = 0; rv[nd] = int'(res); nd++; req0 = 1'b0;
            if (issued0 < 2) begin rearm0 = 1'b1; issued0++; end
         end
         if (done1 && nd < 4) begin
            if (nd > 0 && ord[nd-1] == 1) consec1++;
            ord[nd] = 1; rv[nd] = int'(res); nd++; req1 = 1'b0;
            if (issued1 < 2) begin rearm1 = 1'b1; issued1++; end
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("fair completions", nd, 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("fair grant %0d", i), ord[i], i % 2);
         chk($sformatf("fair res %0d", i), rv[i], (i % 2 == 0) ? 40 : 10);
      end
      chk("fair consecutive done1", consec1, 0);

      // Reset asserted in the fifth CALC cycle
      @(negedge clk);
      dividend0 = W'(1000); divisor0 = W'(7); req0 = 1'b1;
      @(posedge clk);
      repeat (5) @(posedge clk);
      #1;
      chk("midcalc busy before reset", int'(busy), 1);
      #1;
      reset = 1'b1;
      #1;
      chk("midcalc reset res",   int'(res),   0);
      chk("midcalc reset dbz",   int'(dbz),   0);
      chk("midcalc reset done0", int'(done0), 0);
      chk("midcalc reset done1", int'(done1), 0);
      chk("midcalc reset busy",  int'(busy),  0);
      req0 = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      spurious = 0;
      repeat (20) begin
         @(negedge clk);
         if (done0 | done1 | busy) spurious++;
      end
      chk("midcalc no done after reset", spurious, 0);
      run_one(0, 1000, 7, r, z, lat, other, be0);
      chk("reissue res", r, vecs[0].exp_res);
      chk("reissue dbz", z, 0);
      chk("reissue latency", lat, LAT);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
